// File: rtl/adder_bist_checker.sv
// -----------------------------------------------------------------------------
// adder_bist_checker
//
// Built-in self-test controller for a full adder (WIDTH=1) or an N-bit ripple
// adder. It steps an exhaustive {a, b, cin} sequence into the attached adder,
// waits SETTLE cycles per vector, samples {cout, sum} and compares it with
// a + b + cin. It reports a saturating mismatch count, the first failing
// vector and an overall pass flag, so adders can be qualified on silicon/FPGA.
//
// Parameters:
//   WIDTH   operand width of a/b/sum (1..4)
//   SETTLE  cycles between applying a vector and sampling it (>= 1)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   start             begin a run; honoured only in IDLE or DONE
//   a, b, cin         stimulus to the adder under test (registered)
//   sum, cout         response from the adder under test
//   busy              run in progress
//   done              run complete, held until next start or reset
//   pass              done and no mismatches
//   err_count         number of mismatching vectors, saturating
//   first_fail_vec    {a,b,cin} of the first mismatch
//   first_fail_valid  first_fail_vec holds a captured vector
// -----------------------------------------------------------------------------
module adder_bist_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   first_fail_vec,
  output logic               first_fail_valid
);

  localparam int VW     = 2 * WIDTH + 1;
  // The wait counter must exist even when SETTLE is 1 (it then only holds 0).
  localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [VW-1:0]     VEC_MAX   = {VW{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [VW-1:0]       vec_q, vec_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [VW-1:0]       ffv_q, ffv_d;
  logic                ffvalid_q, ffvalid_d;

  logic [WIDTH:0]      expected;
  logic                miss;

  // The stimulus is the vector register itself: a = MSBs, cin = LSB.
  assign a   = vec_q[VW-1 -: WIDTH];
  assign b   = vec_q[WIDTH:1];
  assign cin = vec_q[0];

  // Reference sum at WIDTH+1 bits so the carry-out is kept.
  assign expected = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    vec_d     = vec_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    miss      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SETTLE;
          vec_d     = '0;
          wcnt_d    = WCNT_LOAD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end

      S_SETTLE: begin
        if (wcnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      S_CHECK: begin
        // Written as "equal -> ok, else -> miss" so an X/Z response falls
        // into the mismatch branch in simulation.
        if ({cout, sum} == expected) begin
          miss = 1'b0;
        end else begin
          miss = 1'b1;
        end

        if (miss) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end

        if (vec_q == VEC_MAX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the count including this last vector's result.
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + VW'(1);
          wcnt_d  = WCNT_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      wcnt_q    <= wcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
